// File: rtl/lc3_mem_access.sv
// LC3 memory-access stage: performs the data-memory transaction for LD/LDR/LDI/ST/STR/STI
// over a req/ready handshake with a wait-state timeout, and forwards ALU results for
// non-memory instructions. Indirect forms make a pointer read followed by the final access.
module lc3_mem_access #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned DATA_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              Mem_Control_in,
    input  logic [DATA_W-1:0] IR_Exec,
    input  logic [DATA_W-1:0] pcout,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] M_Data,
    input  logic [1:0]        W_Control_in,
    input  logic [DATA_W-1:0] Data_dout,
    input  logic              Data_ready,
    output logic              Data_req,
    output logic              Data_rd,
    output logic [DATA_W-1:0] Data_addr,
    output logic [DATA_W-1:0] Data_din,
    output logic [DATA_W-1:0] memout,
    output logic              mem_done,
    output logic              mem_err,
    output logic              busy,
    output logic [1:0]        W_Control_out
);

    localparam int unsigned CNT_W    = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
    // Value of the counter during the last permitted wait cycle.
    localparam int unsigned WAIT_MAX = (WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0;

    typedef enum logic [1:0] {
        StIdle,
        StPtr,
        StAcc,
        StDone
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             ind_q;
    logic             wr_q;

    logic [3:0] opcode;
    logic       is_read;
    logic       is_write;
    logic       is_ind;

    // Opcode decode of the instruction presented with start.
    always_comb begin
        opcode   = IR_Exec[DATA_W-1 -: 4];
        is_read  = 1'b0;
        is_write = 1'b0;
        is_ind   = 1'b0;
        unique case (opcode)
            4'b0010, 4'b0110: is_read = 1'b1;
            4'b1010: begin
                is_read = 1'b1;
                is_ind  = 1'b1;
            end
            4'b0011, 4'b0111: is_write = 1'b1;
            4'b1011: begin
                is_write = 1'b1;
                is_ind   = 1'b1;
            end
            default: ;
        endcase
    end

    // Transaction FSM with registered handshake and completion outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= StIdle;
            wait_cnt      <= '0;
            ind_q         <= 1'b0;
            wr_q          <= 1'b0;
            Data_req      <= 1'b0;
            Data_rd       <= 1'b1;
            Data_addr     <= '0;
            Data_din      <= '0;
            memout        <= '0;
            mem_done      <= 1'b0;
            mem_err       <= 1'b0;
            busy          <= 1'b0;
            W_Control_out <= 2'b00;
        end else begin
            mem_done <= 1'b0;
            mem_err  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        busy          <= 1'b1;
                        W_Control_out <= W_Control_in;
                        if (Mem_Control_in && (is_read || is_write)) begin
                            Data_req  <= 1'b1;
                            Data_addr <= pcout;
                            Data_din  <= M_Data;
                            // Pointer fetch of an indirect access is always a read.
                            Data_rd   <= is_ind | is_read;
                            ind_q     <= is_ind;
                            wr_q      <= is_write;
                            wait_cnt  <= '0;
                            state     <= is_ind ? StPtr : StAcc;
                        end else begin
                            memout   <= aluout;
                            mem_done <= 1'b1;
                            state    <= StDone;
                        end
                    end
                end
                StPtr: begin
                    if (Data_ready) begin
                        // Data_req stays high: the final access follows with no gap.
                        Data_addr <= Data_dout;
                        Data_rd   <= ~wr_q;
                        wait_cnt  <= '0;
                        state     <= StAcc;
                    end else if (wait_cnt == CNT_W'(WAIT_MAX)) begin
                        Data_req <= 1'b0;
                        memout   <= '0;
                        mem_done <= 1'b1;
                        mem_err  <= 1'b1;
                        state    <= StDone;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                StAcc: begin
                    if (Data_ready) begin
                        Data_req <= 1'b0;
                        if (!wr_q) begin
                            memout <= Data_dout;
                        end
                        mem_done <= 1'b1;
                        state    <= StDone;
                    end else if (wait_cnt == CNT_W'(WAIT_MAX)) begin
                        Data_req <= 1'b0;
                        memout   <= '0;
                        mem_done <= 1'b1;
                        mem_err  <= 1'b1;
                        state    <= StDone;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    ind_q <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
